// File: rtl/bidir_bus_ctrl_pkg.sv
// Shared definitions for the bidirectional pad bus controller:
// FSM states, register offsets, STATUS bit positions.
package bidir_bus_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_SETUP,
        ST_WR_STB,
        ST_WR_HOLD,
        ST_TURN,
        ST_RD_STB,
        ST_RD_END
    } state_e;

    localparam logic [7:0] OFS_DATA = 8'd0;
    localparam logic [7:0] OFS_CTRL = 8'd1;

    localparam int CTRL_START_WR = 0;
    localparam int CTRL_START_RD = 1;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_TIMEOUT = 2;

    // Saturating 8-bit increment for the ack wait counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/bidir_bus_ctrl_sync2.sv
// Two-flop synchronizer for asynchronous pad/ack inputs.
// Parameterised width, synchronous active-high reset.
module bidir_bus_ctrl_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Two back-to-back flops; only sync_q is used downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/bidir_bus_ctrl.sv
// PicoBlaze port-mapped controller for an IOBUF pad bus.
// Strobe/ack write and read cycles, turnaround and ack timeout.
module bidir_bus_ctrl #(
    parameter int unsigned DATA_W      = 8,
    parameter logic [7:0]  BASE_ADDR   = 8'h10,
    parameter int unsigned TURN_CYC    = 2,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        port_id,
    input  logic              write_strobe,
    input  logic              read_strobe,
    input  logic [7:0]        out_port,
    output logic [7:0]        in_port,
    output logic [DATA_W-1:0] pad_i,
    output logic [DATA_W-1:0] pad_t,
    input  logic [DATA_W-1:0] pad_o,
    output logic              ext_stb,
    output logic              ext_rnw,
    input  logic              ext_ack
);

    import bidir_bus_ctrl_pkg::*;

    localparam logic [7:0] ADDR_DATA = BASE_ADDR + OFS_DATA;
    localparam logic [7:0] ADDR_CTRL = BASE_ADDR + OFS_CTRL;
    localparam logic [7:0] ACK_LIM   = 8'(ACK_TIMEOUT);
    localparam logic [7:0] TURN_LAST = 8'(TURN_CYC - 1);
    localparam logic [DATA_W-1:0] PAD_REL = {DATA_W{1'b1}};

    state_e            state_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] pad_i_q;
    logic [DATA_W-1:0] pad_t_q;
    logic              ext_stb_q;
    logic              ext_rnw_q;
    logic              done_q;
    logic              timeout_q;
    logic [7:0]        ack_cnt_q;
    logic [7:0]        ack_cnt_d;
    logic [7:0]        turn_q;
    logic [7:0]        in_port_q;
    logic [7:0]        in_port_d;
    logic [7:0]        status;
    logic [7:0]        rd_ext;

    logic [DATA_W-1:0] pad_s;
    logic              ack_s;

    logic sel_data;
    logic sel_ctrl;
    logic start_wr;
    logic start_rd;
    logic clr_flags;
    logic ack_expired;
    logic busy;

    bidir_bus_ctrl_sync2 #(.W(DATA_W)) u_sync_pad (
        .clk   (clk),
        .reset (reset),
        .d_i   (pad_o),
        .q_o   (pad_s)
    );

    bidir_bus_ctrl_sync2 #(.W(1)) u_sync_ack (
        .clk   (clk),
        .reset (reset),
        .d_i   (ext_ack),
        .q_o   (ack_s)
    );

    assign sel_data  = (port_id == ADDR_DATA);
    assign sel_ctrl  = (port_id == ADDR_CTRL);
    assign start_wr  = write_strobe && sel_ctrl && out_port[CTRL_START_WR];
    assign start_rd  = write_strobe && sel_ctrl && out_port[CTRL_START_RD];
    assign clr_flags = read_strobe && sel_ctrl;
    assign busy      = (state_q != ST_IDLE);

    // The compare looks at the incremented count so the strobe
    // stays high for exactly ACK_TIMEOUT cycles on a silent device.
    assign ack_cnt_d   = sat_inc8(ack_cnt_q);
    assign ack_expired = (ack_cnt_d == ACK_LIM);

    // Read-back mux, registered below every cycle.
    always_comb begin
        status = 8'h00;
        status[STAT_BUSY]    = busy;
        status[STAT_DONE]    = done_q;
        status[STAT_TIMEOUT] = timeout_q;
        rd_ext = 8'h00;
        rd_ext[DATA_W-1:0] = rd_data_q;
        in_port_d = 8'h00;
        if (sel_data) begin
            in_port_d = rd_ext;
        end else if (sel_ctrl) begin
            in_port_d = status;
        end
    end

    // Register the read data presented to the processor.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_port_q <= 8'h00;
        end else begin
            in_port_q <= in_port_d;
        end
    end

    // Bus cycle FSM with registered pad and strobe outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            wr_data_q <= '0;
            rd_data_q <= '0;
            pad_i_q   <= '0;
            pad_t_q   <= PAD_REL;
            ext_stb_q <= 1'b0;
            ext_rnw_q <= 1'b1;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            ack_cnt_q <= 8'h00;
            turn_q    <= 8'h00;
        end else begin
            if (write_strobe && sel_data) begin
                wr_data_q <= out_port[DATA_W-1:0];
            end
            if (clr_flags) begin
                done_q    <= 1'b0;
                timeout_q <= 1'b0;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (start_wr) begin
                        state_q   <= ST_WR_SETUP;
                        pad_t_q   <= '0;
                        pad_i_q   <= wr_data_q;
                        ext_rnw_q <= 1'b0;
                        done_q    <= 1'b0;
                        timeout_q <= 1'b0;
                    end else if (start_rd) begin
                        state_q   <= ST_RD_STB;
                        ext_stb_q <= 1'b1;
                        ack_cnt_q <= 8'h00;
                        done_q    <= 1'b0;
                        timeout_q <= 1'b0;
                    end
                end
                ST_WR_SETUP: begin
                    state_q   <= ST_WR_STB;
                    ext_stb_q <= 1'b1;
                    ack_cnt_q <= 8'h00;
                end
                ST_WR_STB: begin
                    if (ack_s) begin
                        state_q   <= ST_WR_HOLD;
                        ext_stb_q <= 1'b0;
                    end else if (ack_expired) begin
                        state_q   <= ST_TURN;
                        timeout_q <= 1'b1;
                        ext_stb_q <= 1'b0;
                        pad_t_q   <= PAD_REL;
                        pad_i_q   <= '0;
                        ext_rnw_q <= 1'b1;
                        turn_q    <= 8'h00;
                    end else begin
                        ack_cnt_q <= ack_cnt_d;
                    end
                end
                ST_WR_HOLD: begin
                    state_q   <= ST_TURN;
                    pad_t_q   <= PAD_REL;
                    pad_i_q   <= '0;
                    ext_rnw_q <= 1'b1;
                    turn_q    <= 8'h00;
                end
                ST_TURN: begin
                    if (turn_q == TURN_LAST) begin
                        state_q <= ST_IDLE;
                        if (!timeout_q) begin
                            done_q <= 1'b1;
                        end
                    end else begin
                        turn_q <= turn_q + 8'd1;
                    end
                end
                ST_RD_STB: begin
                    if (ack_s) begin
                        state_q   <= ST_RD_END;
                        rd_data_q <= pad_s;
                        ext_stb_q <= 1'b0;
                    end else if (ack_expired) begin
                        state_q   <= ST_IDLE;
                        timeout_q <= 1'b1;
                        ext_stb_q <= 1'b0;
                    end else begin
                        ack_cnt_q <= ack_cnt_d;
                    end
                end
                ST_RD_END: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    pad_t_q   <= PAD_REL;
                    pad_i_q   <= '0;
                    ext_stb_q <= 1'b0;
                    ext_rnw_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_port = in_port_q;
    assign pad_i   = pad_i_q;
    assign pad_t   = pad_t_q;
    assign ext_stb = ext_stb_q;
    assign ext_rnw = ext_rnw_q;

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// Self-checking bench for bidir_bus_ctrl: directed scenarios plus
// randomized cycles against a pad/device model.
module tb_bidir_bus_ctrl;

    localparam logic [7:0] BASE = 8'h10;
    localparam logic [7:0] CTRL = 8'h11;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] port_id;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] out_port;
    logic [7:0] in_port;
    logic [7:0] pad_i;
    logic [7:0] pad_t;
    logic [7:0] pad_o;
    logic       ext_stb;
    logic       ext_rnw;
    logic       ext_ack;

    int n_checks = 0;
    int n_err    = 0;

    logic       ack_en;
    int         ack_dly;
    logic [7:0] dev_rd;
    logic [7:0] dev_wr;
    int         dev_cnt;
    logic [7:0] pid_seen;

    always #5 clk = ~clk;

    bidir_bus_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .port_id      (port_id),
        .write_strobe (write_strobe),
        .read_strobe  (read_strobe),
        .out_port     (out_port),
        .in_port      (in_port),
        .pad_i        (pad_i),
        .pad_t        (pad_t),
        .pad_o        (pad_o),
        .ext_stb      (ext_stb),
        .ext_rnw      (ext_rnw),
        .ext_ack      (ext_ack)
    );

    // Device: acks once strobe has been seen for ack_dly edges,
    // drives dev_rd on a read cycle, latches pad value on write ack.
    always @(posedge clk) begin
        if (!ext_stb) dev_cnt <= 0;
        else if (dev_cnt < 1000) dev_cnt <= dev_cnt + 1;
        if (ext_ack && !ext_rnw) dev_wr <= pad_o;
    end

    assign ext_ack = ack_en && ext_stb && (dev_cnt >= ack_dly);
    assign pad_o = (~pad_t & pad_i) |
                   (pad_t & ((ext_rnw && ext_stb) ? dev_rd : 8'hFF));

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Continuous checks on every cycle.
    always @(posedge clk) begin
        pid_seen = port_id;
        #2;
        if (ext_rnw) check("rnw_implies_hiz", pad_t, 8'hFF);
        if (pid_seen != BASE && pid_seen != CTRL)
            check("unmapped_in_port", in_port, 8'h00);
    end

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        port_id = a;
        out_port = d;
        write_strobe = 1'b1;
        @(negedge clk);
        write_strobe = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        port_id = a;
        read_strobe = 1'b1;
        @(negedge clk);
        read_strobe = 1'b0;
        d = in_port;
    endtask

    task automatic peek(input logic [7:0] a, output logic [7:0] d);
        port_id = a;
        @(negedge clk);
        d = in_port;
    endtask

    // Observe n cycles starting with the current one.
    task automatic watch(input int n, input logic [7:0] exp_pad,
                         output int stb_c, output int drv_c,
                         output int bad, output int rises);
        logic prev;
        stb_c = 0; drv_c = 0; bad = 0; rises = 0;
        prev = ext_stb;
        for (int i = 0; i < n; i++) begin
            if (ext_stb) stb_c++;
            if (ext_stb && !prev) rises++;
            prev = ext_stb;
            if (pad_t != 8'hFF) begin
                drv_c++;
                if (pad_t != 8'h00 || pad_i != exp_pad || ext_rnw) bad++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [7:0] r;
        logic [7:0] exp_rd;
        logic [7:0] dat;
        int stb_c, drv_c, bad, rises, d, found;

        reset = 1'b1;
        port_id = 8'h00;
        write_strobe = 1'b0;
        read_strobe = 1'b0;
        out_port = 8'h00;
        ack_en = 1'b0;
        ack_dly = 0;
        dev_rd = 8'h00;
        exp_rd = 8'h00;

        repeat (3) @(negedge clk);
        check("rst_pad_t", pad_t, 8'hFF);
        check("rst_pad_i", pad_i, 8'h00);
        check("rst_stb", ext_stb, 1'b0);
        check("rst_rnw", ext_rnw, 1'b1);
        check("rst_in_port", in_port, 8'h00);
        reset = 1'b0;
        cpu_read(BASE, r); check("rst_rd_data", r, 8'h00);
        cpu_read(CTRL, r); check("rst_status", r, 8'h00);

        // Reset in the middle of a strobed write.
        cpu_write(BASE, 8'h5A);
        cpu_write(CTRL, 8'h01);
        for (int i = 0; i < 10 && !ext_stb; i++) @(negedge clk);
        check("mid_stb_started", ext_stb, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_pad_t", pad_t, 8'hFF);
        check("mid_rst_stb", ext_stb, 1'b0);
        peek(CTRL, r); check("mid_rst_status", r, 8'h00);
        watch(10, 8'h00, stb_c, drv_c, bad, rises);
        check("mid_rst_no_stb", stb_c, 0);

        // Write A5, device acks 2 cycles after strobe.
        ack_en = 1'b1;
        ack_dly = 2;
        cpu_write(BASE, 8'hA5);
        cpu_write(CTRL, 8'h01);
        drv_c = 0; stb_c = 0; bad = 0; found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (pad_t == 8'hFF) begin
                found = 1;
            end else begin
                drv_c++;
                if (ext_stb) stb_c++;
                if (pad_t != 8'h00 || pad_i != 8'hA5 || ext_rnw) bad++;
                @(negedge clk);
            end
        end
        check("wrA5_released", found, 1);
        check("wrA5_drive_cycles", drv_c, 2 + 3 + 2);
        check("wrA5_stb_cycles", stb_c, 2 + 3);
        check("wrA5_pad_value", bad, 0);
        check("wrA5_dev_capture", dev_wr, 8'hA5);
        peek(CTRL, r); check("wrA5_turn1", r, 8'h01);
        peek(CTRL, r); check("wrA5_turn2", r, 8'h01);
        peek(CTRL, r); check("wrA5_done", r, 8'h02);
        cpu_read(CTRL, r); check("wrA5_status", r, 8'h02);
        cpu_read(CTRL, r); check("wrA5_cleared", r, 8'h00);

        // Read 3C; pads must stay released throughout.
        dev_rd = 8'h3C;
        ack_dly = 1;
        cpu_write(CTRL, 8'h02);
        watch(15, 8'h00, stb_c, drv_c, bad, rises);
        check("rd3C_no_drive", drv_c, 0);
        check("rd3C_stb_cycles", stb_c, 1 + 3);
        exp_rd = 8'h3C;
        cpu_read(BASE, r); check("rd3C_data", r, exp_rd);
        cpu_read(CTRL, r); check("rd3C_status", r, 8'h02);

        // Write timeout: ack never comes.
        ack_en = 1'b0;
        cpu_write(BASE, 8'h96);
        cpu_write(CTRL, 8'h01);
        watch(270, 8'h96, stb_c, drv_c, bad, rises);
        check("wto_stb_cycles", stb_c, 255);
        check("wto_drive_cycles", drv_c, 256);
        check("wto_pad_value", bad, 0);
        check("wto_released", pad_t, 8'hFF);
        cpu_read(CTRL, r); check("wto_status", r, 8'h04);
        cpu_read(CTRL, r); check("wto_cleared", r, 8'h00);

        // Read timeout: rd_data must keep its old value.
        dev_rd = 8'hE7;
        cpu_write(CTRL, 8'h02);
        watch(270, 8'h00, stb_c, drv_c, bad, rises);
        check("rto_stb_cycles", stb_c, 255);
        check("rto_no_drive", drv_c, 0);
        cpu_read(CTRL, r); check("rto_status", r, 8'h04);
        cpu_read(BASE, r); check("rto_rd_kept", r, exp_rd);

        // Both start bits: write wins; commands while busy ignored.
        ack_en = 1'b1;
        ack_dly = 6;
        cpu_write(BASE, 8'hC3);
        cpu_write(CTRL, 8'h03);
        check("both_is_write", ext_rnw, 1'b0);
        cpu_write(BASE, 8'h77);
        cpu_write(CTRL, 8'h02);
        watch(20, 8'hC3, stb_c, drv_c, bad, rises);
        check("both_pads_kept", bad, 0);
        check("both_drive_left", drv_c, 7);
        check("both_stb_left", stb_c, 6);
        check("both_no_new_stb", rises, 0);
        check("both_dev_capture", dev_wr, 8'hC3);
        cpu_read(BASE, r); check("both_rd_kept", r, exp_rd);
        cpu_read(CTRL, r); check("both_status", r, 8'h02);
        cpu_read(CTRL, r); check("both_cleared", r, 8'h00);

        // The busy-time data write still landed in wr_data.
        ack_dly = 0;
        cpu_write(CTRL, 8'h01);
        watch(15, 8'h77, stb_c, drv_c, bad, rises);
        check("wr77_stb_cycles", stb_c, 3);
        check("wr77_drive_cycles", drv_c, 5);
        check("wr77_pad_value", bad, 0);
        check("wr77_dev_capture", dev_wr, 8'h77);
        cpu_read(CTRL, r); check("wr77_status", r, 8'h02);

        // Randomized write/read cycles.
        for (int k = 0; k < 8; k++) begin
            dat = 8'($urandom);
            d = int'($urandom_range(0, 4));
            ack_dly = d;
            if ($urandom_range(0, 1) == 0) begin
                cpu_write(BASE, dat);
                cpu_write(CTRL, 8'h01);
                watch(20, dat, stb_c, drv_c, bad, rises);
                check("rnd_wr_stb", stb_c, d + 3);
                check("rnd_wr_drive", drv_c, d + 5);
                check("rnd_wr_pad", bad, 0);
                check("rnd_wr_dev", dev_wr, dat);
            end else begin
                dev_rd = dat;
                cpu_write(CTRL, 8'h02);
                watch(20, 8'h00, stb_c, drv_c, bad, rises);
                check("rnd_rd_stb", stb_c, d + 3);
                check("rnd_rd_drive", drv_c, 0);
                exp_rd = dat;
                cpu_read(BASE, r); check("rnd_rd_data", r, exp_rd);
            end
            cpu_read(CTRL, r); check("rnd_status", r, 8'h02);
        end

        // Unmapped addresses read as zero.
        cpu_read(8'h12, r); check("unmapped_12", r, 8'h00);
        cpu_read(8'h0F, r); check("unmapped_0F", r, 8'h00);
        dat = 8'($urandom_range(32, 255));
        cpu_read(dat, r); check("unmapped_rnd", r, 8'h00);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
